// File: rtl/pc_unit.sv
// pc_unit: program-counter unit with sequential, beq/bne, j/jal and jr/jalr
// next-PC sources, link capture, misaligned-target trap with EPC, and a
// retired-update counter.
// Optional feature macro: PC_RAS_EN adds a RAS_DEPTH-entry return-address
// stack (informational only). Without it ras_top/ras_valid read as zero.
module pc_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0180),
  parameter int                INC       = 4,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              branch,
  input  logic              branch_ne,
  input  logic              zero,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic              link,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_inc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              redirect,
  output logic              misalign,
  output logic [ADDR_W-1:0] epc,
  output logic [31:0]       retired,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_valid
);

  // INC is a power of two, so INC-1 masks exactly the low log2(INC) bits.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;
  logic              redirect_q, redirect_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [31:0]       retired_q, retired_d;

  logic [ADDR_W-1:0] target_sel;
  logic              non_seq;
  logic              target_bad;

  assign pc_plus_inc = pc_q + ADDR_W'(INC);

  // Pick the non-sequential target by strict priority jr > jump > taken branch.
  always_comb begin
    target_sel = '0;
    non_seq    = 1'b0;
    if (jr) begin
      target_sel = jr_target;
      non_seq    = 1'b1;
    end else if (jump) begin
      target_sel = jump_target;
      non_seq    = 1'b1;
    end else if (branch && (branch_ne ? !zero : zero)) begin
      target_sel = branch_target;
      non_seq    = 1'b1;
    end
    target_bad = non_seq && ((target_sel & ALIGN_MASK) != '0);
  end

  // Next-state for PC, link, redirect, trap bookkeeping and retired count.
  always_comb begin
    pc_d        = pc_q;
    link_addr_d = link_addr_q;
    redirect_d  = redirect_q;
    misalign_d  = misalign_q;
    epc_d       = epc_q;
    retired_d   = retired_q;
    if (en) begin
      retired_d  = retired_q + 32'd1;
      redirect_d = non_seq;
      if (target_bad) begin
        pc_d = EXC_VEC;
        if (!misalign_q) begin
          epc_d      = target_sel;
          misalign_d = 1'b1;
        end
      end else if (non_seq) begin
        pc_d = target_sel;
      end else begin
        pc_d = pc_plus_inc;
      end
      if (link) begin
        link_addr_d = pc_plus_inc;
      end
    end
  end

  // Architectural state registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_VEC;
      link_addr_q <= '0;
      redirect_q  <= 1'b0;
      misalign_q  <= 1'b0;
      epc_q       <= '0;
      retired_q   <= '0;
    end else begin
      pc_q        <= pc_d;
      link_addr_q <= link_addr_d;
      redirect_q  <= redirect_d;
      misalign_q  <= misalign_d;
      epc_q       <= epc_d;
      retired_q   <= retired_d;
    end
  end

  assign pc        = pc_q;
  assign link_addr = link_addr_q;
  assign redirect  = redirect_q;
  assign misalign  = misalign_q;
  assign epc       = epc_q;
  assign retired   = retired_q;

`ifdef PC_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_idx_q, ras_idx_d;
  logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;

  // Circular stack: pop first, then push, so jalr replaces the top in place
  // and a push when full silently overwrites the oldest slot.
  always_comb begin
    ras_mem_d = ras_mem_q;
    ras_idx_d = ras_idx_q;
    ras_cnt_d = ras_cnt_q;
    if (en) begin
      if (jr && (ras_cnt_q != '0)) begin
        ras_idx_d = (ras_idx_q == '0) ? LAST_IDX : ras_idx_q - PTR_W'(1);
        ras_cnt_d = ras_cnt_q - CNT_W'(1);
      end
      if (link) begin
        ras_idx_d = (ras_idx_d == LAST_IDX) ? '0 : ras_idx_d + PTR_W'(1);
        ras_mem_d[ras_idx_d] = pc_plus_inc;
        if (ras_cnt_d != FULL_CNT) begin
          ras_cnt_d = ras_cnt_d + CNT_W'(1);
        end
      end
    end
  end

  // Stack storage and pointers, emptied on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_q[i] <= '0;
      end
      ras_idx_q <= LAST_IDX;
      ras_cnt_q <= '0;
    end else begin
      ras_mem_q <= ras_mem_d;
      ras_idx_q <= ras_idx_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  assign ras_valid = (ras_cnt_q != '0);
  assign ras_top   = ras_valid ? ras_mem_q[ras_idx_q] : '0;
`else
  assign ras_top   = '0;
  assign ras_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit. Inputs are driven on
// the falling edge and outputs sampled 1 time unit after the rising edge.
module tb_pc_unit;

  logic        clock;
  logic        reset;
  logic        en;
  logic        branch;
  logic        branch_ne;
  logic        zero;
  logic [31:0] branch_target;
  logic        jump;
  logic        link;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus_inc;
  logic [31:0] link_addr;
  logic        redirect;
  logic        misalign;
  logic [31:0] epc;
  logic [31:0] retired;
  logic [31:0] ras_top;
  logic        ras_valid;

  int checks;
  int failures;
  logic [31:0] exp_retired;

  pc_unit dut (
    .clock         (clock),
    .reset         (reset),
    .en            (en),
    .branch        (branch),
    .branch_ne     (branch_ne),
    .zero          (zero),
    .branch_target (branch_target),
    .jump          (jump),
    .link          (link),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .pc            (pc),
    .pc_plus_inc   (pc_plus_inc),
    .link_addr     (link_addr),
    .redirect      (redirect),
    .misalign      (misalign),
    .epc           (epc),
    .retired       (retired),
    .ras_top       (ras_top),
    .ras_valid     (ras_valid)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one set of controls for exactly one rising edge, then park idle.
  task automatic applyStimulus(input logic i_en, input logic i_branch,
                               input logic i_ne, input logic i_zero,
                               input logic [31:0] i_bt, input logic i_jump,
                               input logic i_link, input logic [31:0] i_jt,
                               input logic i_jr, input logic [31:0] i_jrt);
    @(negedge clock);
    en            = i_en;
    branch        = i_branch;
    branch_ne     = i_ne;
    zero          = i_zero;
    branch_target = i_bt;
    jump          = i_jump;
    link          = i_link;
    jump_target   = i_jt;
    jr            = i_jr;
    jr_target     = i_jrt;
    @(posedge clock);
    #1;
    if (i_en) exp_retired = exp_retired + 32'd1;
    en = 1'b0; branch = 1'b0; branch_ne = 1'b0; zero = 1'b0; jump = 1'b0;
    link = 1'b0; jr = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; exp_retired = 0;
    en = 0; branch = 0; branch_ne = 0; zero = 0; branch_target = 0;
    jump = 0; link = 0; jump_target = 0; jr = 0; jr_target = 0;
    reset = 1'b1;
    #3;
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_pc_plus_inc", pc_plus_inc, 32'h4);
    checkOutput("reset_link", link_addr, 32'h0);
    checkOutput("reset_redirect", {31'b0, redirect}, 32'h0);
    checkOutput("reset_misalign", {31'b0, misalign}, 32'h0);
    checkOutput("reset_epc", epc, 32'h0);
    checkOutput("reset_retired", retired, 32'h0);
    checkOutput("reset_ras_top", ras_top, 32'h0);
    checkOutput("reset_ras_valid", {31'b0, ras_valid}, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] sequential advance and hold");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("seq_pc1", pc, 32'h4);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("seq_pc2", pc, 32'h8);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("seq_pc3", pc, 32'hC);
    checkOutput("seq_retired", retired, 32'd3);
    checkOutput("seq_redirect", {31'b0, redirect}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h500, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hold_pc", pc, 32'hC);
    checkOutput("hold_retired", retired, 32'd3);
    checkOutput("hold_pc_plus_inc", pc_plus_inc, 32'h10);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("seq_pc4", pc, 32'h10);

    $display("[TB] conditional branches");
    applyStimulus(1, 1, 0, 1, 32'h40, 0, 0, 0, 0, 0);
    checkOutput("beq_taken_pc", pc, 32'h40);
    checkOutput("beq_taken_redirect", {31'b0, redirect}, 32'h1);
    checkOutput("beq_retired", retired, 32'd5);
    applyStimulus(1, 1, 1, 1, 32'h80, 0, 0, 0, 0, 0);
    checkOutput("bne_not_taken_pc", pc, 32'h44);
    checkOutput("bne_not_taken_redirect", {31'b0, redirect}, 32'h0);
    applyStimulus(1, 1, 1, 0, 32'h20, 0, 0, 0, 0, 0);
    checkOutput("bne_taken_pc", pc, 32'h20);
    checkOutput("bne_taken_redirect", {31'b0, redirect}, 32'h1);

    $display("[TB] priority and link");
    applyStimulus(1, 1, 0, 1, 32'h300, 1, 1, 32'h200, 1, 32'h100);
    checkOutput("prio_jr_pc", pc, 32'h100);
    checkOutput("prio_link", link_addr, 32'h24);
    applyStimulus(1, 1, 0, 1, 32'h300, 1, 0, 32'h200, 0, 0);
    checkOutput("prio_jump_pc", pc, 32'h200);
    checkOutput("link_hold", link_addr, 32'h24);

    $display("[TB] misaligned targets");
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h8, 0, 0);
    checkOutput("jump8_pc", pc, 32'h8);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h202, 0, 0);
    checkOutput("mis1_pc", pc, 32'h180);
    checkOutput("mis1_flag", {31'b0, misalign}, 32'h1);
    checkOutput("mis1_epc", epc, 32'h202);
    checkOutput("mis1_redirect", {31'b0, redirect}, 32'h1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, 32'h301);
    checkOutput("mis2_pc", pc, 32'h180);
    checkOutput("mis2_epc", epc, 32'h202);
    checkOutput("mis2_link", link_addr, 32'h184);
    applyStimulus(1, 1, 0, 0, 32'h3, 0, 0, 0, 0, 0);
    checkOutput("untaken_bad_target_pc", pc, 32'h184);
    checkOutput("untaken_bad_target_redirect", {31'b0, redirect}, 32'h0);
    checkOutput("misalign_sticky", {31'b0, misalign}, 32'h1);
    checkOutput("retired_model", retired, exp_retired);

    $display("[TB] asynchronous reset mid-cycle");
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h48, 0, 0);
    checkOutput("jump48_pc", pc, 32'h48);
    #2;
    reset = 1'b1;
    #1;
    exp_retired = 0;
    checkOutput("async_pc", pc, 32'h0);
    checkOutput("async_misalign", {31'b0, misalign}, 32'h0);
    checkOutput("async_retired", retired, 32'h0);
    checkOutput("async_epc", epc, 32'h0);
    checkOutput("async_link", link_addr, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_reset_pc", pc, 32'h4);
    checkOutput("post_reset_retired", retired, 32'd1);

    $display("[TB] address wrap");
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 0);
    checkOutput("wrap_pc_plus_inc", pc_plus_inc, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_pc", pc, 32'h0);

    $display("[TB] return-address stack");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 1, 1, 32'(i + 1) << 4, 0, 0);
    end
    checkOutput("jal_chain_pc", pc, 32'h50);
    checkOutput("jal_chain_link", link_addr, 32'h44);
`ifdef PC_RAS_EN
    checkOutput("ras_full_top", ras_top, 32'h44);
    checkOutput("ras_full_valid", {31'b0, ras_valid}, 32'h1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100);
    checkOutput("ras_pop1", ras_top, 32'h34);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100);
    checkOutput("ras_pop2", ras_top, 32'h24);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100);
    checkOutput("ras_pop3", ras_top, 32'h14);
    checkOutput("ras_pop3_valid", {31'b0, ras_valid}, 32'h1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100);
    checkOutput("ras_pop4", ras_top, 32'h0);
    checkOutput("ras_pop4_valid", {31'b0, ras_valid}, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100);
    checkOutput("ras_pop5", ras_top, 32'h0);
    checkOutput("ras_pop5_valid", {31'b0, ras_valid}, 32'h0);
    checkOutput("ras_jr_pc", pc, 32'h100);
`else
    checkOutput("ras_off_top", ras_top, 32'h0);
    checkOutput("ras_off_valid", {31'b0, ras_valid}, 32'h0);
`endif
    checkOutput("final_retired", retired, exp_retired);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-cycle/multicycle core; successor to the beq-only PC.
- Holds the fetch PC and advances it on an enable strobe.
- Selects next PC from sequential, conditional branch (beq/bne), jump/jal, and jr sources.
- Captures link addresses, traps misaligned targets to an exception vector with a saved EPC, and counts retired PC updates.

Parameters:
- ADDR_W, 32, width of PC and all address ports
- RESET_VEC, 32'h0000_0000, PC value on reset
- EXC_VEC, 32'h0000_0180, PC loaded on a misaligned target
- INC, 4, sequential increment; must be a power of two
- RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  1  advance strobe; PC and all state hold when 0
- branch  in  1  conditional branch instruction
- branch_ne  in  1  when 1 the branch is bne (taken on !zero); when 0 it is beq (taken on zero)
- zero  in  1  ALU zero flag
- branch_target  in  ADDR_W  ALU-computed branch address
- jump  in  1  unconditional jump (j/jal)
- link  in  1  jal/jalr: capture return address
- jump_target  in  ADDR_W  pseudo-direct jump address
- jr  in  1  register jump (jr/jalr)
- jr_target  in  ADDR_W  register value for jr
- pc  out  ADDR_W  current fetch PC
- pc_plus_inc  out  ADDR_W  combinational pc + INC
- link_addr  out  ADDR_W  registered return address
- redirect  out  1  registered; 1 when the last update was non-sequential
- misalign  out  1  sticky misaligned-target flag
- epc  out  ADDR_W  offending target address of the first misalignment
- retired  out  32  count of accepted PC updates
- ras_top  out  ADDR_W  top of return-address stack
- ras_valid  out  1  stack non-empty

Behaviour:
- Reset (async, any time including mid-update):
  - pc=RESET_VEC; link_addr=0; redirect=0; misalign=0; epc=0; retired=0; RAS emptied; ras_top=0; ras_valid=0.
  - Takes effect immediately, without waiting for a clock edge.
- Update rule: state changes only on a rising clock edge with en=1. With en=0 every register holds, including retired.
- Next-PC priority, highest first:
  - jr -> jr_target
  - jump -> jump_target
  - branch && (branch_ne ? !zero : zero) -> branch_target
  - otherwise pc_plus_inc
- Simultaneous control inputs resolve strictly by the priority above. A branch that is not taken, with no jump or jr, is sequential.
- Arithmetic: pc + INC wraps modulo 2^ADDR_W; no carry out.
- Alignment check: a target is misaligned when its low log2(INC) bits are non-zero. It applies only to a selected non-sequential target.
- On a misaligned target:
  - pc=EXC_VEC.
  - If misalign was 0: epc=target and misalign=1.
  - If misalign was already 1: epc holds, and the flag stays set until reset.
  - redirect=1.
- Link: when link=1 on an accepted update (whether jump or jr), link_addr = pc_plus_inc of the current pc. The link is still captured when the target is misaligned.
- redirect: 1 after any accepted update whose source is not sequential (including an exception); 0 after a sequential update; holds when en=0.
- retired: increments by 1 on every accepted update and wraps from 0xFFFFFFFF to 0.
- Latency: new pc visible one clock after the en-qualified edge. pc_plus_inc follows pc combinationally.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: RAS_DEPTH-entry return-address stack.
  - Push: on an accepted update with link=1, push pc_plus_inc.
  - Pop: on an accepted update with jr=1, pop.
  - jr && link (jalr): pop then push, so the top is replaced and depth is unchanged.
  - Push when full overwrites the oldest entry (circular); occupancy saturates at RAS_DEPTH.
  - Pop when empty: no change.
  - ras_top = most recent entry, or 0 when empty. ras_valid = occupancy != 0.
  - The stack is informational only and never overrides jr_target.
- Undefined: no stack storage; ras_top tied to 0 and ras_valid to 0; push/pop ignored.

Test Plan:
1. Reset, then 3 edges with en=1 and no controls -> pc 0,4,8,12; retired=3; redirect=0. Then en=0 for 2 edges -> pc stays 12, retired stays 3.
2. pc=0x10, branch=1, branch_ne=0, zero=1, target=0x40 -> pc=0x40, redirect=1. Repeat with branch_ne=1 -> pc=0x44, redirect=0.
3. jr=1 (0x100), jump=1 (0x200) and taken branch (0x300) all asserted at pc=0x20, link=1 -> pc=0x100, link_addr=0x24.
4. jump_target=0x202 at pc=0x8 -> pc=0x180, misalign=1, epc=0x202. A second misaligned jr to 0x301 -> pc=0x180, epc remains 0x202.
5. Assert reset asynchronously between edges mid-run at pc=0x48 -> pc=0 immediately, misalign=0, retired=0.
6. With PC_RAS_EN and RAS_DEPTH=4: 5 jal pushes from pc 0x0,0x10,0x20,0x30,0x40 -> ras_top=0x44, depth=4. Then 5 jr -> ras_top sequence 0x34,0x24,0x14, then 0 with ras_valid=0, and the extra pop is ignored.
